fdiv_round: RTL

Post-divide normalize/round stage for the single-precision FP divide path. It captures the sign, exponents and special-operand class of an FP divide at issue time, then waits for the 32-bit quotient mantissa from the Newton divider (format x.xxx…x with a sticky LSB). It then normalizes, rounds, adjusts the exponent, resolves special cases and returns a packed IEEE-754 single result with exception flags. It sits directly downstream of the mantissa divider and shares its `ena` pipeline enable.

---
 rtl/fdiv_round.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fdiv_round.sv
// Post-divide normalize/round stage for single-precision FP divide.
// Captures operand info at issue, then packs the rounded IEEE result when the quotient arrives.
module fdiv_round (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ena,
  input  logic        issue,
  input  logic [31:0] fa,
  input  logic [31:0] fb,
  input  logic [1:0]  rm,
  input  logic [31:0] q,
  input  logic        q_valid,
  output logic [31:0] res,
  output logic        res_valid,
  output logic [4:0]  flags,
  output logic        pend
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [2:0] {C_NORM, C_ZERO, C_INF, C_QNAN, C_SNAN} cls_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  state_t      state, state_nx;
  logic        sign_r;
  logic [7:0]  ea_r, eb_r;
  logic [1:0]  rm_r;
  cls_t        cls_a, cls_b;

  logic        done;
  logic        capture;

  function automatic cls_t classify(input logic [31:0] f);
    cls_t c;
    c = C_NORM;
    if (f[30:23] == 8'h00)          c = C_ZERO;
    else if (f[30:23] == 8'hFF) begin
      if (f[22:0] == 23'd0)         c = C_INF;
      else if (f[22])               c = C_QNAN;
      else                          c = C_SNAN;
    end
    return c;
  endfunction

  assign pend    = (state == S_WAIT);
  assign done    = (state == S_WAIT) && q_valid && ena;
  assign capture = (state == S_IDLE) && issue && ena;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Completion has priority: a same-edge issue is only honoured from IDLE later.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (capture) state_nx = S_WAIT;
      S_WAIT: if (done)    state_nx = S_IDLE;
      default:             state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sign_r <= 1'b0;
      ea_r   <= '0;
      eb_r   <= '0;
      rm_r   <= '0;
      cls_a  <= C_NORM;
      cls_b  <= C_NORM;
    end else if (capture) begin
      sign_r <= fa[31] ^ fb[31];
      ea_r   <= fa[30:23];
      eb_r   <= fb[30:23];
      rm_r   <= rm;
      cls_a  <= classify(fa);
      cls_b  <= classify(fb);
    end
  end

  logic [23:0]        mant;
  logic               g, s, inc;
  logic [24:0]        sum;
  logic signed [9:0]  e_base, e_fin;
  logic               a_nan, b_nan, any_snan;
  logic               to_inf;
  logic [31:0]        res_d;
  logic [4:0]         flags_d;

  always_comb begin
    if (q[31]) begin
      mant = q[31:8];
      g    = q[7];
      s    = |q[6:0];
    end else begin
      mant = q[30:7];
      g    = q[6];
      s    = |q[5:0];
    end

    case (rm_r)
      2'b00:   inc = g & (s | mant[0]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~sign_r & (g | s);
      default: inc = sign_r & (g | s);
    endcase

    sum    = {1'b0, mant} + {24'd0, inc};
    e_base = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
             + (q[31] ? 10'sd127 : 10'sd126);
    e_fin  = e_base + $signed({9'd0, sum[24]});

    a_nan    = (cls_a == C_QNAN) || (cls_a == C_SNAN);
    b_nan    = (cls_b == C_QNAN) || (cls_b == C_SNAN);
    any_snan = (cls_a == C_SNAN) || (cls_b == C_SNAN);
    to_inf   = (rm_r == 2'b00) || (rm_r == 2'b10 && !sign_r) || (rm_r == 2'b11 && sign_r);

    res_d   = '0;
    flags_d = '0;
    if (a_nan || b_nan) begin
      res_d      = QNAN;
      flags_d[4] = any_snan;
    end else if ((cls_a == C_ZERO && cls_b == C_ZERO) || (cls_a == C_INF && cls_b == C_INF)) begin
      res_d      = QNAN;
      flags_d[4] = 1'b1;
    end else if (cls_a == C_INF || cls_b == C_ZERO) begin
      res_d      = {sign_r, 31'h7F800000};
      flags_d[3] = (cls_a != C_INF);
    end else if (cls_a == C_ZERO || cls_b == C_INF) begin
      res_d      = {sign_r, 31'd0};
    end else if (e_fin > 10'sd254) begin
      res_d      = to_inf ? {sign_r, 31'h7F800000} : {sign_r, 31'h7F7FFFFF};
      flags_d    = 5'b00101;
    end else if (e_fin < 10'sd1) begin
      res_d      = {sign_r, 31'd0};
      flags_d    = 5'b00011;
    end else begin
      res_d      = {sign_r, e_fin[7:0], sum[22:0]};
      flags_d[0] = g | s;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res       <= '0;
      flags     <= '0;
      res_valid <= 1'b0;
    end else if (!ena) begin
      res_valid <= 1'b0;
    end else begin
      res_valid <= done;
      if (done) begin
        res   <= res_d;
        flags <= flags_d;
      end
    end
  end

endmodule
